alu_sched: RTL
==============

# alu_sched

Two-requester scheduler that shares the single combinational `alu` instance between two independent command sources. Accepts one command per cycle slot through valid/ready handshakes, arbitrates round-robin, registers operands and results, and returns Z plus flags on one shared response channel tagged with the requester ID. Also keeps a saturating count of overflowing operations for status readout.

## Interface

- `OVF_CNT_W`, 8, width of the saturating overflow-event counter

- `clk` in 1: single clock, rising edge
- `rst_n` in 1: reset, asynchronous assert, active-low
- `req0_valid` / `req1_valid` in 1: command present on port k
- `req0_ready` / `req1_ready` out 1: command on port k accepted this cycle
- `req0_op` / `req1_op` in 4: ALU op_code
- `req0_x`, `req0_y` / `req1_x`, `req1_y` in 32: operands
- `rsp_valid` out 1: response held stable until accepted
- `rsp_ready` in 1: consumer accepts response
- `rsp_id` out 1: requester that issued the command
- `rsp_z` out 32: ALU result
- `rsp_overflow`, `rsp_equal`, `rsp_zero` out 1: ALU flags
- `rsp_illegal` out 1: op_code reserved (4, 11–15)
- `ovf_count` out OVF_CNT_W: overflow events, saturating
- `clr_count` in 1: synchronous clear of `ovf_count`

## Operation

- FSM states: IDLE, EXEC, RESP.
- `can_accept` = (state == IDLE) or (state == RESP and `rsp_ready`).
- Grant: one valid requester → that one. Both valid → requester ≠ `last_grant`. `last_grant` resets to 1, so req0 wins first contention. It updates only on an accepted handshake.
- `reqk_ready` = `can_accept` and grant==k. At most one ready per cycle. Ready may depend on valid; requesters must not make valid depend on ready.
- On accept: op, x, y, and id are captured into operand registers, and the FSM moves to EXEC.
- EXEC: ALU driven from operand registers. Z, flags, and illegal are captured into response registers. FSM moves to RESP.
- RESP: `rsp_valid`=1 and all rsp_* outputs are stable.
  - `rsp_ready`=1 with a new accept → EXEC.
  - `rsp_ready`=1 with no request → IDLE.
  - Otherwise hold.
- Illegal ops: accepted normally. `rsp_z`=0, all flags 0 (ALU behaviour), `rsp_illegal`=1.
- Counter:
  - Increments by 1 on each response handshake with `rsp_overflow`=1.
  - Saturates at all-ones with no wrap.
  - `clr_count` has priority over increment in the same cycle; the result is 0.
- Reset (any time, including mid-EXEC/RESP):
  - State → IDLE; `last_grant`=1; in-flight command dropped without a response.
  - All outputs 0: `rsp_valid`, `rsp_*`, `ovf_count`, and both readies. Readies rise combinationally after deassertion if valid is present.

## Timing

- Accept handshake in cycle n → EXEC in n+1 → `rsp_valid` high in n+2. Latency is 2 cycles.
- Back-to-back: response handshake and new accept in cycle m → next `rsp_valid` in m+2. Peak throughput is 1 op per 2 cycles.
- Back-pressure: `rsp_ready`=0 stalls in RESP indefinitely. Both `reqk_ready` stay 0 during the stall.
- `ovf_count` updates on the edge ending the handshake cycle. It is visible the following cycle.
- No combinational path from `rsp_ready` to `rsp_*` data. The only such paths are `rsp_ready` → `reqk_ready`.

## Structure

- Shared package `alu_pkg`:
  - op_code localparams: AND=0, OR=1, XOR=2, NOR=3, ADD=5, SUB=6, SLT=7, SRL=8, SLL=9, SRA=10.
  - `is_reserved_op` function.
  - FSM state encoding.
- Sub-modules: the existing `alu`, instantiated once, plus `rr_arb2` (2-way round-robin grant holding `last_grant`).

## Test plan

- **Single ADD:** req0 ADD x=3 y=4 → `req0_ready`=1 same cycle; two cycles later `rsp_valid`=1, `rsp_id`=0, `rsp_z`=7, all flags 0.
- **Contention:** both requesters hold SUB 5−5 continuously with `rsp_ready`=1 → grants alternate 0,1,0,1. Each response has `rsp_z`=0, `rsp_equal`=1, `rsp_zero`=1. One response every 2 cycles.
- **Back-pressure:** `rsp_ready`=0 for 5 cycles with req1 OR 0xF0|0x0F pending → `rsp_z`=0xFF held stable; both readies 0. Release → req1 accepted the same cycle.
- **Illegal op:** op 12, x=1, y=1 → `rsp_z`=0, `rsp_illegal`=1, flags 0; `ovf_count` unchanged.
- **Counter:** 300 ADD 0xFFFFFFFF+1 handshakes → `ovf_count`=255 (saturated). Assert `clr_count` together with an overflowing handshake → 0.
- **Mid-op reset:** assert `rst_n`=0 while in RESP → `rsp_valid` drops immediately. After release, a req0/req1 tie grants req0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, scheduler state encoding and bus payload types.
package alu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned SH_W   = 5;

    localparam logic [OP_W-1:0] OP_AND = 4'd0;
    localparam logic [OP_W-1:0] OP_OR  = 4'd1;
    localparam logic [OP_W-1:0] OP_XOR = 4'd2;
    localparam logic [OP_W-1:0] OP_NOR = 4'd3;
    localparam logic [OP_W-1:0] OP_ADD = 4'd5;
    localparam logic [OP_W-1:0] OP_SUB = 4'd6;
    localparam logic [OP_W-1:0] OP_SLT = 4'd7;
    localparam logic [OP_W-1:0] OP_SRL = 4'd8;
    localparam logic [OP_W-1:0] OP_SLL = 4'd9;
    localparam logic [OP_W-1:0] OP_SRA = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } sched_state_e;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] x;
        logic [DATA_W-1:0] y;
        logic              id;
    } cmd_t;

    typedef struct packed {
        logic [DATA_W-1:0] z;
        logic              overflow;
        logic              equal;
        logic              zero;
        logic              illegal;
        logic              id;
    } rsp_t;

    function automatic logic is_reserved_op(input logic [OP_W-1:0] op);
        return (op == 4'd4) || (op >= 4'd11);
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU; overflow is unsigned carry (ADD) / borrow (SUB); reserved ops yield all zeros.
module alu
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] x_i,
    input  logic [DATA_W-1:0] y_i,
    input  logic [OP_W-1:0]   op_i,
    output logic [DATA_W-1:0] z_o,
    output logic              overflow_o,
    output logic              equal_o,
    output logic              zero_o
);

    logic [DATA_W:0]   sum_w;
    logic [DATA_W:0]   diff_w;
    logic [SH_W-1:0]   sh;
    logic              legal;

    always_comb begin
        z_o        = '0;
        overflow_o = 1'b0;
        sum_w      = {1'b0, x_i} + {1'b0, y_i};
        diff_w     = {1'b0, x_i} - {1'b0, y_i};
        sh         = y_i[SH_W-1:0];
        legal      = !is_reserved_op(op_i);
        case (op_i)
            OP_AND: z_o = x_i & y_i;
            OP_OR:  z_o = x_i | y_i;
            OP_XOR: z_o = x_i ^ y_i;
            OP_NOR: z_o = ~(x_i | y_i);
            OP_ADD: begin
                z_o        = sum_w[DATA_W-1:0];
                overflow_o = sum_w[DATA_W];
            end
            OP_SUB: begin
                z_o        = diff_w[DATA_W-1:0];
                overflow_o = diff_w[DATA_W];
            end
            OP_SLT: z_o = DATA_W'($signed(x_i) < $signed(y_i));
            OP_SRL: z_o = x_i >> sh;
            OP_SLL: z_o = x_i << sh;
            OP_SRA: z_o = DATA_W'($signed(x_i) >>> sh);
            default: z_o = '0;
        endcase
        equal_o = legal && (x_i == y_i);
        zero_o  = legal && (z_o == '0);
    end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; last grant advances only on an accepted handshake.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic       gnt_o
);

    logic last_q;

    always_comb begin
        gnt_o = req_i[1];
        if (req_i == 2'b11) begin
            gnt_o = ~last_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (accept_i) begin
            last_q <= gnt_o;
        end
    end

endmodule

// File: rtl/alu_sched.sv
// Shares one ALU between two requesters: round-robin accept, 2-cycle registered
// execution, single tagged response channel and a saturating overflow counter.
module alu_sched
    import alu_pkg::*;
#(
    parameter int unsigned OVF_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [OP_W-1:0]      req0_op,
    input  logic [DATA_W-1:0]    req0_x,
    input  logic [DATA_W-1:0]    req0_y,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [OP_W-1:0]      req1_op,
    input  logic [DATA_W-1:0]    req1_x,
    input  logic [DATA_W-1:0]    req1_y,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [DATA_W-1:0]    rsp_z,
    output logic                 rsp_overflow,
    output logic                 rsp_equal,
    output logic                 rsp_zero,
    output logic                 rsp_illegal,
    output logic [OVF_CNT_W-1:0] ovf_count,
    input  logic                 clr_count
);

    sched_state_e          state_q, state_d;
    cmd_t                  cmd_q, cmd_d;
    rsp_t                  rsp_q, rsp_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [OVF_CNT_W-1:0]  cnt_q, cnt_d;

    logic                  gnt;
    logic                  can_accept;
    logic                  accept;
    logic                  rsp_hs;
    logic [DATA_W-1:0]     alu_z;
    logic                  alu_ovf;
    logic                  alu_eq;
    logic                  alu_zero;

    rr_arb2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    ({req1_valid, req0_valid}),
        .accept_i (accept),
        .gnt_o    (gnt)
    );

    alu u_alu (
        .x_i        (cmd_q.x),
        .y_i        (cmd_q.y),
        .op_i       (cmd_q.op),
        .z_o        (alu_z),
        .overflow_o (alu_ovf),
        .equal_o    (alu_eq),
        .zero_o     (alu_zero)
    );

    // Readies are the only rsp_ready-dependent paths; held low while reset is asserted.
    always_comb begin
        can_accept = (state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready);
        req0_ready = rst_n && can_accept && req0_valid && !gnt;
        req1_ready = rst_n && can_accept && req1_valid && gnt;
        accept     = req0_ready || req1_ready;
        rsp_hs     = rsp_valid_q && rsp_ready;
    end

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        rsp_d       = rsp_q;
        rsp_valid_d = rsp_valid_q;
        cnt_d       = cnt_q;

        if (accept) begin
            cmd_d.op = gnt ? req1_op : req0_op;
            cmd_d.x  = gnt ? req1_x  : req0_x;
            cmd_d.y  = gnt ? req1_y  : req0_y;
            cmd_d.id = gnt;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_d.z        = alu_z;
                rsp_d.overflow = alu_ovf;
                rsp_d.equal    = alu_eq;
                rsp_d.zero     = alu_zero;
                rsp_d.illegal  = is_reserved_op(cmd_q.op);
                rsp_d.id       = cmd_q.id;
                rsp_valid_d    = 1'b1;
                state_d        = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = accept ? ST_EXEC : ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase

        // Clear wins over a coincident overflowing handshake.
        if (clr_count) begin
            cnt_d = '0;
        end else if (rsp_hs && rsp_q.overflow && !(&cnt_q)) begin
            cnt_d = cnt_q + OVF_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cmd_q       <= '0;
            rsp_q       <= '0;
            rsp_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            rsp_q       <= rsp_d;
            rsp_valid_q <= rsp_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_id       = rsp_q.id;
    assign rsp_z        = rsp_q.z;
    assign rsp_overflow = rsp_q.overflow;
    assign rsp_equal    = rsp_q.equal;
    assign rsp_zero     = rsp_q.zero;
    assign rsp_illegal  = rsp_q.illegal;
    assign ovf_count    = cnt_q;

endmodule
